kf_seq: RTL

KF_SEQ -- requirements
Module: kf_seq

---
 rtl/kf_pkg.sv | 42 ++++
 rtl/kf_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/kf_pkg.sv
// kf_pkg -- shared definitions for the kf_seq program sequencer.
//
// Holds the opcode values, the sequencer state encoding and the bit
// positions of each field inside the 18-bit instruction word
// {op[2:0], dst[4:0], srca[4:0], srcb[4:0]}.
package kf_pkg;

  localparam int INSTR_W  = 18;
  localparam int FIELD_W  = 5;

  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 15;
  localparam int DST_MSB  = 14;
  localparam int DST_LSB  = 10;
  localparam int SRCA_MSB = 9;
  localparam int SRCA_LSB = 5;
  localparam int SRCB_MSB = 4;
  localparam int SRCB_LSB = 0;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_WQ   = 3'd3;
  localparam logic [2:0] OP_WD   = 3'd4;
  localparam logic [2:0] OP_WAIT = 3'd5;
  localparam logic [2:0] OP_ILL  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Pull the opcode field out of an instruction word.
  function automatic logic [2:0] instrOp(input logic [INSTR_W-1:0] instrWord);
    return instrWord[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/kf_seq.sv
// kf_seq -- small microprogram sequencer driving a data bank, two
// accumulators and an external arithmetic unit.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   launch program at pc=0 (only looked at while idle)
//   last_pc   in   index of the final instruction
//   pc        out  program memory address (memory answers one cycle later)
//   instr     in   instruction word {op, dst, srca, srcb}
//   alu_done  in   arithmetic unit completion pulse (only used while waiting)
//   dira      out  data bank address A (read or write)
//   dirb      out  data bank address B (read)
//   write     out  data bank write enable
//   rq_we     out  RQ accumulator write enable
//   rd_we     out  RD accumulator write enable
//   alu_go    out  operand-valid pulse to the arithmetic unit
//   busy      out  high whenever the sequencer is not idle
//   done      out  one-cycle completion pulse
//   err       out  sticky error (illegal opcode or WAIT timeout)
module kf_seq
  import kf_pkg::*;
#(
  parameter int ADDRW = 5,
  parameter int PCW   = 6,
  parameter int TMO   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PCW-1:0]     last_pc,
  output logic [PCW-1:0]     pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_done,
  output logic [ADDRW-1:0]   dira,
  output logic [ADDRW-1:0]   dirb,
  output logic               write,
  output logic               rq_we,
  output logic               rd_we,
  output logic               alu_go,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // The wait counter only ever has to reach TMO-1 before timing out.
  localparam int CNTW = (TMO < 2) ? 1 : $clog2(TMO);

  state_t              r_state;
  state_t              w_stateNext;
  logic [PCW-1:0]      r_pc;
  logic [PCW-1:0]      w_pcNext;
  logic                r_err;
  logic                w_errNext;
  logic [CNTW-1:0]     r_waitCnt;
  logic [CNTW-1:0]     w_waitCntNext;
  logic                w_advance;

  logic [2:0]          w_op;
  logic [FIELD_W-1:0]  w_dst;
  logic [FIELD_W-1:0]  w_srcA;
  logic [FIELD_W-1:0]  w_srcB;

  assign w_op   = instrOp(instr);
  assign w_dst  = instr[DST_MSB:DST_LSB];
  assign w_srcA = instr[SRCA_MSB:SRCA_LSB];
  assign w_srcB = instr[SRCB_MSB:SRCB_LSB];

  assign pc  = r_pc;
  assign err = r_err;

  // State register plus the pc, sticky error and wait counter. Reset is
  // checked first so it beats start and alu_done arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_err     <= 1'b0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_err     <= w_errNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  // Next-state and output decode. Strobes and bank addresses are purely
  // combinational from the current state and the opcode on instr, so they
  // are only ever non-zero while executing. Finishing an ordinary
  // instruction (or a WAIT that saw alu_done) is funnelled through
  // w_advance so the "stop at last_pc, never wrap" rule lives in one place.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_errNext     = r_err;
    w_waitCntNext = r_waitCnt;
    w_advance     = 1'b0;
    dira          = '0;
    dirb          = '0;
    write         = 1'b0;
    rq_we         = 1'b0;
    rd_we         = 1'b0;
    alu_go        = 1'b0;
    busy          = (r_state != ST_IDLE);
    done          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext   = ST_FETCH;
          w_pcNext      = '0;
          w_errNext     = 1'b0;
          w_waitCntNext = '0;
        end
      end

      ST_FETCH: begin
        w_stateNext = ST_EXEC;
      end

      ST_EXEC: begin
        case (w_op)
          OP_RD: begin
            dira      = ADDRW'(w_srcA);
            dirb      = ADDRW'(w_srcB);
            alu_go    = 1'b1;
            w_advance = 1'b1;
          end
          OP_WR: begin
            dira      = ADDRW'(w_dst);
            write     = 1'b1;
            w_advance = 1'b1;
          end
          OP_WQ: begin
            rq_we     = 1'b1;
            w_advance = 1'b1;
          end
          OP_WD: begin
            rd_we     = 1'b1;
            w_advance = 1'b1;
          end
          OP_WAIT: begin
            w_stateNext   = ST_WAIT;
            w_waitCntNext = '0;
          end
          OP_HALT: begin
            w_stateNext = ST_DONE;
          end
          OP_ILL: begin
            w_errNext = 1'b1;
            w_advance = 1'b1;
          end
          default: begin
            w_advance = 1'b1;
          end
        endcase
      end

      ST_WAIT: begin
        if (alu_done) begin
          w_advance = 1'b1;
        end else if (r_waitCnt == CNTW'(TMO - 1)) begin
          w_errNext   = 1'b1;
          w_stateNext = ST_DONE;
        end else begin
          w_waitCntNext = r_waitCnt + CNTW'(1);
        end
      end

      ST_DONE: begin
        done        = 1'b1;
        w_stateNext = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    if (w_advance) begin
      if (r_pc == last_pc) begin
        w_stateNext = ST_DONE;
      end else begin
        w_pcNext    = r_pc + PCW'(1);
        w_stateNext = ST_FETCH;
      end
    end
  end

endmodule
